// File: rtl/sand_mem_arbiter.sv
// Fixed-priority (port 0 > 1 > 2) arbiter sharing one Avalon-MM SDRAM master, with read timeout.
// Define SAND_ARB_STARVE_GUARD_EN to force port 2 to win after STARVE_LIMIT consecutive losses.
module sand_mem_arbiter #(
   parameter int AW           = 24,
   parameter int DW           = 16,
   parameter int NREQ         = 3,
   parameter int RD_TIMEOUT   = 255,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      done,
   output logic [DW-1:0]        rdata,
   output logic                 err,
   output logic                 busy,
   output logic [AW-1:0]        mem_address,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [DW-1:0]        mem_writedata,
   input  logic                 mem_waitrequest,
   input  logic                 mem_readdatavalid,
   input  logic [1:0]           mem_response,
   input  logic [DW-1:0]        mem_readdata
);

   localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW   = $clog2(RD_TIMEOUT + 1);
   localparam int LAST = NREQ - 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [AW-1:0]   mem_address_q, mem_address_d;
   logic [DW-1:0]   mem_writedata_q, mem_writedata_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic [TW-1:0]   tmo_q, tmo_d;

   logic [AW-1:0]   addr_a  [NREQ];
   logic [DW-1:0]   wdata_a [NREQ];
   logic [NREQ-1:0] eligible;
   logic            pick_valid;
   logic [GW-1:0]   pick_idx;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_a[gi]  = addr[gi*AW +: AW];
      assign wdata_a[gi] = wdata[gi*DW +: DW];
   end

`ifdef SAND_ARB_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;
`endif

   // A port completing this cycle has not yet had a chance to drop or re-present its request.
   always_comb begin
      eligible   = req & ~done_q;
      pick_valid = |eligible;
      pick_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (eligible[i]) pick_idx = GW'(i);
      end
`ifdef SAND_ARB_STARVE_GUARD_EN
      if (eligible[LAST] && (starve_q >= 4'(STARVE_LIMIT))) pick_idx = GW'(LAST);
`endif
   end

`ifdef SAND_ARB_STARVE_GUARD_EN
   always_comb begin
      starve_d = starve_q;
      if ((state_q == ST_IDLE) && pick_valid) begin
         if (pick_idx == GW'(LAST)) starve_d = '0;
         else if (req[LAST] && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`endif

   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      done_d          = '0;
      rdata_d         = rdata_q;
      err_d           = err_q;
      busy_d          = busy_q;
      tmo_d           = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d         = pick_idx;
               mem_address_d   = addr_a[pick_idx];
               mem_writedata_d = wdata_a[pick_idx];
               mem_read_d      = ~we[pick_idx];
               mem_write_d     = we[pick_idx];
               busy_d          = 1'b1;
               state_d         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!mem_waitrequest) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_write_q) begin
                  done_d[grant_q] = 1'b1;
                  err_d           = 1'b0;
                  busy_d          = 1'b0;
                  state_d         = ST_IDLE;
               end else begin
                  tmo_d   = '0;
                  state_d = ST_RDWAIT;
               end
            end
         end
         ST_RDWAIT: begin
            // Data arriving on the timeout cycle still takes precedence over the forced error.
            if (mem_readdatavalid) begin
               rdata_d         = mem_readdata;
               err_d           = |mem_response;
               done_d[grant_q] = 1'b1;
               busy_d          = 1'b0;
               state_d         = ST_IDLE;
            end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
               rdata_d         = '0;
               err_d           = 1'b1;
               done_d[grant_q] = 1'b1;
               busy_d          = 1'b0;
               state_d         = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         grant_q         <= '0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         done_q          <= '0;
         rdata_q         <= '0;
         err_q           <= 1'b0;
         busy_q          <= 1'b0;
         tmo_q           <= '0;
      end else begin
         state_q         <= state_d;
         grant_q         <= grant_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         done_q          <= done_d;
         rdata_q         <= rdata_d;
         err_q           <= err_d;
         busy_q          <= busy_d;
         tmo_q           <= tmo_d;
      end
   end

   assign done          = done_q;
   assign rdata         = rdata_q;
   assign err           = err_q;
   assign busy          = busy_q;
   assign mem_address   = mem_address_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_writedata = mem_writedata_q;

endmodule
